// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared register offsets, bit indices, receiver states and helpers for ps2_rx_fifo.
package ps2_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_FRM_ERR = 3;
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_MASK = 1;
  localparam int CTRL_FLUSH = 7;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  function automatic logic [3:0] sat4(input int unsigned n);
    return n > 15 ? 4'd15 : 4'(n);
  endfunction
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: CPU I/O-window bus for ps2_rx_fifo.
// sel/addr/rd_n/wr_n/din driven by the CPU side (master); dout/doe/irq driven by the block (slave).
interface ps2_rx_fifo_if;
  logic sel;
  logic [1:0] addr;
  logic rd_n;
  logic wr_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic doe;
  logic irq;
  modport master(output sel, addr, rd_n, wr_n, din, input dout, doe, irq);
  modport slave(input sel, addr, rd_n, wr_n, din, output dout, doe, irq);
endinterface

// File: rtl/ps2_rx_fifo_frame_rx.sv
// ps2_frame_rx: PS/2 frame receiver (synchroniser, glitch-qualified sampling, frame FSM, inter-bit timeout).
// Ports: CLK, RST (sync, active-low), kb_clk/kb_data (async PS/2 lines), en (hold idle when 0),
// byte_valid/rx_byte (one-cycle good frame), frame_err (one-cycle framing/parity/timeout error).
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DLY = 8,
  parameter int TIMEOUT_CYC = 36864
) (
  input  logic CLK,
  input  logic RST,
  input  logic kb_clk,
  input  logic kb_data,
  input  logic en,
  output logic byte_valid,
  output logic [7:0] rx_byte,
  output logic frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] kc_s, kd_s;
  logic [3:0] cnt;
  logic armed, strobe, fire, tout;
  logic [TW-1:0] tcnt;
  rx_state_t state, nxt;
  logic [2:0] idx, n_idx;
  logic [7:0] sh, n_sh;
  logic par, n_par;
  wire kc = kc_s[1];
  wire kd = kd_s[1];
  // armed is consumed by the strobe so a long low phase yields exactly one sample
  assign fire = ~kc & armed & (cnt == 4'(SAMPLE_DLY - 1));
  assign tout = tcnt == TW'(TIMEOUT_CYC - 1);
  assign rx_byte = sh;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      kc_s <= 2'b11;
      kd_s <= 2'b11;
      cnt <= '0;
      armed <= 1'b0;
      strobe <= 1'b0;
      tcnt <= '0;
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
    end else begin
      kc_s <= {kc_s[0], kb_clk};
      kd_s <= {kd_s[0], kb_data};
      cnt <= kc ? 4'd0 : armed ? cnt + 4'd1 : cnt;
      armed <= kc ? 1'b1 : fire ? 1'b0 : armed;
      strobe <= fire;
      tcnt <= (state == IDLE || strobe) ? '0 : tcnt + 1'b1;
      state <= nxt;
      idx <= n_idx;
      sh <= n_sh;
      par <= n_par;
    end
  end
  always_comb begin
    nxt = state;
    n_idx = idx;
    n_sh = sh;
    n_par = par;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    if (!en) begin
      nxt = IDLE;
      n_idx = '0;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          nxt = kd ? IDLE : DATA;
          n_idx = '0;
          frame_err = kd;
        end
        DATA: begin
          n_sh = {kd, sh[7:1]};
          n_idx = idx + 3'd1;
          nxt = idx == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          n_par = kd;
          nxt = STOP;
        end
        default: begin
          byte_valid = kd & (^{sh, par});
          frame_err = ~(kd & (^{sh, par}));
          nxt = IDLE;
        end
      endcase
    end else if (state != IDLE && tout) begin
      nxt = IDLE;
      n_idx = '0;
      frame_err = 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 receiver with scan-code FIFO and CPU register file (DATA/STATUS/CTRL).
// Ports: CLK, RST (sync, active-low), KB_CLK/KB_DATA (async PS/2 lines), bus (ps2_rx_fifo_if.slave).
// Optional: define PS2_IRQ_EN for a masked, registered IRQ; otherwise IRQ is tied 0 and CTRL bit1 reads 0.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_DLY = 8,
  parameter int TIMEOUT_CYC = 36864
) (
  input  logic CLK,
  input  logic RST,
  input  logic KB_CLK,
  input  logic KB_DATA,
  ps2_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, cnt;
  logic en, mask, ovf, frm, rd_seen, wr_q;
  logic byte_valid, frame_err;
  logic [7:0] rx_byte, rdata;
  logic empty, full, wr_stb, st_wr, ctrl_wr, flush, do_pop, do_push;
  logic unused;
  ps2_frame_rx #(.SAMPLE_DLY(SAMPLE_DLY), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .CLK(CLK),
    .RST(RST),
    .kb_clk(KB_CLK),
    .kb_data(KB_DATA),
    .en(en),
    .byte_valid(byte_valid),
    .rx_byte(rx_byte),
    .frame_err(frame_err)
  );
  assign cnt = wp - rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign wr_stb = bus.sel & ~bus.wr_n & ~wr_q;
  assign st_wr = wr_stb & (bus.addr == REG_STATUS);
  assign ctrl_wr = wr_stb & (bus.addr == REG_CTRL);
  assign flush = ctrl_wr & bus.din[CTRL_FLUSH];
  // pop fires once, on the first clock that sees RD_N high after a DATA read strobe
  assign do_pop = rd_seen & bus.rd_n & ~empty;
  assign do_push = byte_valid & (~full | do_pop);
  assign unused = ^{bus.din[6:4], bus.din[1]};
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wp <= '0;
      rp <= '0;
      en <= 1'b1;
      ovf <= 1'b0;
      frm <= 1'b0;
      rd_seen <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      wr_q <= bus.sel & ~bus.wr_n;
      rd_seen <= (bus.sel & ~bus.rd_n & (bus.addr == REG_DATA)) | (rd_seen & ~bus.rd_n);
      wp <= flush ? '0 : wp + (AW + 1)'(do_push);
      rp <= flush ? '0 : rp + (AW + 1)'(do_pop);
      ovf <= (byte_valid & full & ~do_pop) | (ovf & ~(st_wr & bus.din[ST_OVF]));
      frm <= frame_err | (frm & ~(st_wr & bus.din[ST_FRM_ERR]));
      if (ctrl_wr) en <= bus.din[CTRL_ENABLE];
    end
  end
  always_ff @(posedge CLK) if (do_push) mem[wp[AW-1:0]] <= rx_byte;
`ifdef PS2_IRQ_EN
  logic irq_q;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mask <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) mask <= bus.din[CTRL_IRQ_MASK];
      irq_q <= mask & (~empty | ovf | frm);
    end
  end
  assign bus.irq = irq_q;
`else
  assign mask = 1'b0;
  assign bus.irq = 1'b0;
`endif
  always_comb begin
    rdata = bus.addr == REG_DATA ? (empty ? 8'h00 : mem[rp[AW-1:0]]) :
            bus.addr == REG_STATUS ? {sat4(32'(cnt)), frm, ovf, full, ~empty} :
            bus.addr == REG_CTRL ? {6'b0, mask, en} : 8'h00;
  end
  assign bus.doe = bus.sel & ~bus.rd_n;
  assign bus.dout = bus.doe ? rdata : 8'h00;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed self-checking bench for ps2_rx_fifo.
module tb_ps2_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic kb_clk = 1'b1;
  logic kb_data = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  ps2_rx_fifo_if bus();
  ps2_rx_fifo dut(.CLK(clk), .RST(rst), .KB_CLK(kb_clk), .KB_DATA(kb_data), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nb, input int half);
    for (int i = 0; i < nb; i++) begin
      kb_data = f[i];
      tick(half);
      kb_clk = 1'b0;
      tick(half);
      kb_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good, input int half);
    logic p;
    p = good ? ~^b : ^b;
    send_bits({1'b1, p, b, 1'b0}, 11, half);
    kb_data = 1'b1;
    tick(20);
  endtask

  task automatic cpu_rd(input logic [1:0] a, input int hold, output logic [7:0] d, output logic oe);
    bus.sel = 1'b1;
    bus.addr = a;
    bus.rd_n = 1'b0;
    tick(hold);
    @(negedge clk);
    d = bus.dout;
    oe = bus.doe;
    @(posedge clk);
    #1;
    bus.rd_n = 1'b1;
    bus.sel = 1'b0;
    tick(3);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    bus.sel = 1'b1;
    bus.addr = a;
    bus.din = d;
    bus.wr_n = 1'b0;
    tick(3);
    bus.wr_n = 1'b1;
    bus.sel = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic oe;
    @(negedge clk);
    n_cmp++;
    if (bus.dout !== 8'h00 || bus.doe !== 1'b0 || bus.irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs dout=%h doe=%b irq=%b want 00 0 0", bus.dout, bus.doe, bus.irq);
    end
    rst = 1'b1;
    tick(5);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_status got %h doe=%b want 00 doe=1", d, oe);
    end
    cpu_rd(2'd2, 1, d, oe);
    n_cmp++;
    if (d !== 8'h01) begin
      n_bad++;
      $display("FAIL reset_ctrl got %h want 01", d);
    end
    cpu_rd(2'd0, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data got %h want 00", d);
    end
  endtask

  task automatic test_frame;
    logic [7:0] d;
    logic oe;
    send_frame(8'h1C, 1'b1, 800);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL frame_status got %h want 11", d);
    end
    cpu_rd(2'd0, 1, d, oe);
    n_cmp++;
    if (d !== 8'h1C) begin
      n_bad++;
      $display("FAIL frame_data got %h want 1c", d);
    end
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL frame_status_after got %h want 00", d);
    end
  endtask

  task automatic test_parity;
    logic [7:0] d;
    logic oe;
    send_frame(8'hF0, 1'b0, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h08) begin
      n_bad++;
      $display("FAIL parity_status got %h want 08", d);
    end
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL parity_clear got %h want 00", d);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic oe;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h87) begin
      n_bad++;
      $display("FAIL ovf_status got %h want 87", d);
    end
    for (int i = 1; i <= 9; i++) begin
      cpu_rd(2'd0, 1, d, oe);
      n_cmp++;
      if (d !== (i == 9 ? 8'h00 : 8'(i))) begin
        n_bad++;
        $display("FAIL ovf_read%0d got %h want %h", i, d, i == 9 ? 8'h00 : 8'(i));
      end
    end
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h04) begin
      n_bad++;
      $display("FAIL ovf_sticky got %h want 04", d);
    end
    cpu_wr(2'd1, 8'h04);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ovf_clear got %h want 00", d);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    logic oe;
    send_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 5, 50);
    kb_data = 1'b1;
    tick(36864 + 10);
    send_frame(8'h5A, 1'b1, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h19) begin
      n_bad++;
      $display("FAIL timeout_status got %h want 19", d);
    end
    cpu_rd(2'd0, 1, d, oe);
    n_cmp++;
    if (d !== 8'h5A) begin
      n_bad++;
      $display("FAIL timeout_data got %h want 5a", d);
    end
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL timeout_after got %h want 00", d);
    end
  endtask

  task automatic test_glitch_long_read;
    logic [7:0] d;
    logic oe;
    for (int i = 0; i < 3; i++) begin
      kb_clk = 1'b0;
      tick(3);
      kb_clk = 1'b1;
      tick(10);
    end
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL glitch_status got %h want 00", d);
    end
    send_frame(8'h33, 1'b1, 50);
    send_frame(8'h44, 1'b1, 50);
    cpu_rd(2'd0, 20, d, oe);
    n_cmp++;
    if (d !== 8'h33) begin
      n_bad++;
      $display("FAIL glitch_data got %h want 33", d);
    end
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL long_read_one_pop got %h want 11", d);
    end
    cpu_rd(2'd0, 1, d, oe);
    n_cmp++;
    if (d !== 8'h44) begin
      n_bad++;
      $display("FAIL long_read_next got %h want 44", d);
    end
  endtask

  task automatic test_ctrl;
    logic [7:0] d;
    logic oe;
    cpu_wr(2'd2, 8'h00);
    cpu_rd(2'd2, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ctrl_disable got %h want 00", d);
    end
    send_frame(8'h12, 1'b1, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ctrl_disabled_rx got %h want 00", d);
    end
    cpu_wr(2'd2, 8'h01);
    send_frame(8'h21, 1'b1, 50);
    send_frame(8'h22, 1'b1, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h21) begin
      n_bad++;
      $display("FAIL ctrl_two_entries got %h want 21", d);
    end
    cpu_wr(2'd2, 8'h81);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL ctrl_flush got %h want 00", d);
    end
    cpu_rd(2'd2, 1, d, oe);
    n_cmp++;
    if (d !== 8'h01) begin
      n_bad++;
      $display("FAIL ctrl_flush_selfclear got %h want 01", d);
    end
    cpu_wr(2'd3, 8'hFF);
    cpu_rd(2'd3, 1, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL reserved_read got %h want 00", d);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic oe;
    send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 5, 50);
    kb_data = 1'b1;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(5);
    send_frame(8'h29, 1'b1, 50);
    cpu_rd(2'd1, 1, d, oe);
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL midreset_status got %h want 11", d);
    end
    cpu_rd(2'd0, 1, d, oe);
    n_cmp++;
    if (d !== 8'h29) begin
      n_bad++;
      $display("FAIL midreset_data got %h want 29", d);
    end
  endtask

  task automatic test_irq;
    logic [7:0] d;
    logic oe;
    cpu_wr(2'd2, 8'h03);
    send_frame(8'h1C, 1'b1, 50);
`ifdef PS2_IRQ_EN
    @(negedge clk);
    n_cmp++;
    if (bus.irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_assert got %b want 1", bus.irq);
    end
    cpu_rd(2'd0, 1, d, oe);
    @(negedge clk);
    n_cmp++;
    if (bus.irq !== 1'b0 || d !== 8'h1C) begin
      n_bad++;
      $display("FAIL irq_drain irq=%b data=%h want 0 1c", bus.irq, d);
    end
`else
    @(negedge clk);
    n_cmp++;
    if (bus.irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_tied got %b want 0", bus.irq);
    end
    cpu_rd(2'd2, 1, d, oe);
    n_cmp++;
    if (d !== 8'h01) begin
      n_bad++;
      $display("FAIL irq_mask_absent got %h want 01", d);
    end
    cpu_rd(2'd0, 1, d, oe);
`endif
  endtask

  initial begin
    bus.sel = 1'b0;
    bus.addr = 2'd0;
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.din = 8'h00;
    tick(5);
    test_reset;
    test_frame;
    test_parity;
    test_overflow;
    test_timeout;
    test_glitch_long_read;
    test_ctrl;
    test_reset_midframe;
    test_irq;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
